// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS pipeline constants, ALU class encodings and the
//                decoded control bundle carried from ID into EX.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MIPS_DATA_W  = 32;
    localparam int MIPS_RADDR_W = 5;

    // Coarse ALU class produced by the main decoder
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,   // loads/stores/addi
        ALU_SUB   = 2'b01,   // branch compare
        ALU_RTYPE = 2'b10,   // decode further from funct
        ALU_LOGI  = 2'b11    // andi/ori/xori/lui
    } alu_op_e;

    // Decoded control bits; all-zero is a harmless bubble
    typedef struct packed {
        logic    reg_dst;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : ID-side inputs, redirect/busy controls and EX-side registered
//                outputs of the ID/EX pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) ();
    // Decode stage side
    logic               id_valid;
    logic               id_reg_dst, id_mem_to_reg, id_mem_read, id_mem_write;
    logic               id_alu_src, id_reg_write, id_branch, id_jump;
    logic [1:0]         id_alu_op;
    logic [DATA_W-1:0]  id_pc4, id_rd1, id_rd2, id_imm;
    logic [RADDR_W-1:0] id_rs, id_rt, id_rd;
    logic [5:0]         id_funct;

    // Pipeline control
    logic               flush;
    logic               ex_busy;
    logic               stall;

    // Execute stage side
    logic               ex_valid;
    logic               ex_reg_dst, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic               ex_alu_src, ex_reg_write, ex_branch, ex_jump;
    logic [1:0]         ex_alu_op;
    logic [DATA_W-1:0]  ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [RADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0]         ex_funct;
    logic [31:0]        perf_stall_cnt;

    // Driver of decoded instructions / consumer of EX fields
    modport master (
        output id_valid, id_reg_dst, id_mem_to_reg, id_mem_read, id_mem_write,
               id_alu_src, id_reg_write, id_branch, id_jump, id_alu_op,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               flush, ex_busy,
        input  stall, ex_valid, ex_reg_dst, ex_mem_to_reg, ex_mem_read,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_branch, ex_jump,
               ex_alu_op, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_funct, perf_stall_cnt
    );

    // The pipeline register itself
    modport slave (
        input  id_valid, id_reg_dst, id_mem_to_reg, id_mem_read, id_mem_write,
               id_alu_src, id_reg_write, id_branch, id_jump, id_alu_op,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               flush, ex_busy,
        output stall, ex_valid, ex_reg_dst, ex_mem_to_reg, ex_mem_read,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_branch, ex_jump,
               ex_alu_op, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_funct, perf_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use hazard detection between the load in EX and the
//                instruction in ID. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  wire logic               ex_valid,
    input  wire logic               ex_mem_read,
    input  wire logic [RADDR_W-1:0] ex_rt,
    input  wire logic               id_valid,
    input  wire logic [RADDR_W-1:0] id_rs,
    input  wire logic [RADDR_W-1:0] id_rt,
    input  wire logic               id_alu_src,
    input  wire logic               id_mem_write,
    input  wire logic               id_branch,
    output logic                    load_use
);
    logic rt_is_source;
    logic rs_hit;
    logic rt_hit;

    // rt only matters when ID actually reads it (R-type, store data, branch)
    always_comb begin
        rt_is_source = ~id_alu_src | id_mem_write | id_branch;
        rs_hit       = (ex_rt == id_rs);
        rt_hit       = (ex_rt == id_rt) & rt_is_source;
        load_use     = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid
                     & (rs_hit | rt_hit);
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with flush, EX-busy hold and
//                load-use bubble insertion. Optional stall-cycle performance
//                counter enabled by defining ID_EX_STALL_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = MIPS_DATA_W,
    parameter int RADDR_W = MIPS_RADDR_W
) (
    input  wire logic     clk,
    input  wire logic     reset,      // asynchronous, active low
    id_ex_stage_if.slave  bus
);
    ctrl_t              w_id_ctrl;
    logic               w_load_use;
    logic               w_stall;
    logic               w_bubble;

    logic               r_valid;
    ctrl_t              r_ctrl;
    logic [DATA_W-1:0]  r_pc4, r_rd1, r_rd2, r_imm;
    logic [RADDR_W-1:0] r_rs, r_rt, r_rd;
    logic [5:0]         r_funct;

    hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard_detect (
        .ex_valid     (r_valid),
        .ex_mem_read  (r_ctrl.mem_read),
        .ex_rt        (r_rt),
        .id_valid     (bus.id_valid),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_alu_src   (bus.id_alu_src),
        .id_mem_write (bus.id_mem_write),
        .id_branch    (bus.id_branch),
        .load_use     (w_load_use)
    );

    // Pack decoded control; an invalid ID slot contributes an all-zero bundle
    always_comb begin
        w_id_ctrl = '0;
        if (bus.id_valid) begin
            w_id_ctrl.reg_dst    = bus.id_reg_dst;
            w_id_ctrl.mem_to_reg = bus.id_mem_to_reg;
            w_id_ctrl.mem_read   = bus.id_mem_read;
            w_id_ctrl.mem_write  = bus.id_mem_write;
            w_id_ctrl.alu_src    = bus.id_alu_src;
            w_id_ctrl.reg_write  = bus.id_reg_write;
            w_id_ctrl.branch     = bus.id_branch;
            w_id_ctrl.jump       = bus.id_jump;
            w_id_ctrl.alu_op     = alu_op_e'(bus.id_alu_op);
        end
    end

    // Stall is gated by reset so it drops the moment reset asserts
    always_comb begin
        w_stall  = reset & ~bus.flush & (bus.ex_busy | w_load_use);
        w_bubble = bus.flush | (~bus.ex_busy & w_load_use);
    end

    // Pipeline register: flush > busy hold > load-use bubble > normal load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_funct <= '0;
        end else if (bus.flush || !bus.ex_busy) begin
            // Data fields are don't-care in a bubble, so they load regardless
            r_valid <= w_bubble ? 1'b0 : bus.id_valid;
            r_ctrl  <= w_bubble ? ctrl_t'('0) : w_id_ctrl;
            r_pc4   <= bus.id_pc4;
            r_rd1   <= bus.id_rd1;
            r_rd2   <= bus.id_rd2;
            r_imm   <= bus.id_imm;
            r_rs    <= bus.id_rs;
            r_rt    <= bus.id_rt;
            r_rd    <= bus.id_rd;
            r_funct <= bus.id_funct;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of edges on which the front end was held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = r_stall_cnt;
`else
    assign bus.perf_stall_cnt = 32'd0;
`endif

    assign bus.stall         = w_stall;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_reg_dst    = r_ctrl.reg_dst;
    assign bus.ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.ex_mem_read   = r_ctrl.mem_read;
    assign bus.ex_mem_write  = r_ctrl.mem_write;
    assign bus.ex_alu_src    = r_ctrl.alu_src;
    assign bus.ex_reg_write  = r_ctrl.reg_write;
    assign bus.ex_branch     = r_ctrl.branch;
    assign bus.ex_jump       = r_ctrl.jump;
    assign bus.ex_alu_op     = r_ctrl.alu_op;
    assign bus.ex_pc4        = r_pc4;
    assign bus.ex_rd1        = r_rd1;
    assign bus.ex_rd2        = r_rd2;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_rs         = r_rs;
    assign bus.ex_rt         = r_rt;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_funct      = r_funct;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Directed self-checking bench for id_ex_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if #(.DATA_W(32), .RADDR_W(5)) bus ();

    id_ex_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        bus.id_valid = 1'b0;      bus.id_reg_dst = 1'b0;  bus.id_mem_to_reg = 1'b0;
        bus.id_mem_read = 1'b0;   bus.id_mem_write = 1'b0; bus.id_alu_src = 1'b0;
        bus.id_reg_write = 1'b0;  bus.id_branch = 1'b0;   bus.id_jump = 1'b0;
        bus.id_alu_op = 2'b00;    bus.id_pc4 = '0;        bus.id_rd1 = '0;
        bus.id_rd2 = '0;          bus.id_imm = '0;        bus.id_rs = '0;
        bus.id_rt = '0;           bus.id_rd = '0;         bus.id_funct = '0;
    endtask

    task automatic set_addi(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        set_nop();
        bus.id_valid = 1'b1; bus.id_alu_src = 1'b1; bus.id_reg_write = 1'b1;
        bus.id_pc4 = pc4; bus.id_rs = rs; bus.id_rt = rt; bus.id_imm = imm;
    endtask

    task automatic set_lw(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt);
        set_addi(pc4, rs, rt, 32'd4);
        bus.id_mem_read = 1'b1; bus.id_mem_to_reg = 1'b1;
    endtask

    task automatic set_add(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_nop();
        bus.id_valid = 1'b1; bus.id_reg_dst = 1'b1; bus.id_reg_write = 1'b1;
        bus.id_alu_op = 2'b10; bus.id_funct = 6'h20;
        bus.id_pc4 = pc4; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] with_macro);
`ifdef ID_EX_STALL_CNT_EN
        chk(tag, bus.perf_stall_cnt, with_macro);
`else
        chk(tag, bus.perf_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.ex_busy = 1'b0;
        set_nop();

        // Reset state
        step(); step();
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_reg_write", bus.ex_reg_write, 0);
        chk("rst_pc4", bus.ex_pc4, 0);
        chk("rst_stall", bus.stall, 0);
        chk_cnt("rst_cnt", 0);

        // addi rt=3 enters EX one edge after reset release
        set_addi(32'h104, 5'd1, 5'd3, 32'd5);
        reset = 1'b1;
        step();
        chk("addi_valid", bus.ex_valid, 1);
        chk("addi_reg_write", bus.ex_reg_write, 1);
        chk("addi_alu_op", bus.ex_alu_op, 2'b00);
        chk("addi_rt", bus.ex_rt, 3);
        chk("addi_imm", bus.ex_imm, 5);
        chk("addi_stall", bus.stall, 0);

        // lw rt=5 then add rs=5: one-cycle load-use bubble
        set_lw(32'h108, 5'd2, 5'd5);
        step();
        chk("lw_mem_read", bus.ex_mem_read, 1);
        set_add(32'h10c, 5'd5, 5'd6, 5'd7);
        #1;
        chk("lu_stall", bus.stall, 1);
        step();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_mem_read", bus.ex_mem_read, 0);
        chk("lu_bubble_reg_write", bus.ex_reg_write, 0);
        chk("lu_stall_cleared", bus.stall, 0);
        chk_cnt("lu_cnt", 1);
        step();
        chk("add_valid", bus.ex_valid, 1);
        chk("add_rs", bus.ex_rs, 5);
        chk("add_rd", bus.ex_rd, 7);
        chk("add_funct", bus.ex_funct, 6'h20);
        chk("add_alu_op", bus.ex_alu_op, 2'b10);

        // lw rt=5 then addi reading rt=5 only as destination: no hazard
        set_lw(32'h110, 5'd2, 5'd5);
        step();
        set_addi(32'h114, 5'd1, 5'd5, 32'd9);
        #1;
        chk("rt_imm_no_stall", bus.stall, 0);
        step();

        // lw rt=0 then add rs=0: $zero never stalls
        set_lw(32'h118, 5'd2, 5'd0);
        step();
        set_add(32'h120, 5'd0, 5'd0, 5'd7);
        #1;
        chk("zero_no_stall", bus.stall, 0);
        step();
        chk("zero_add_valid", bus.ex_valid, 1);
        chk("zero_add_reg_dst", bus.ex_reg_dst, 1);

        // ex_busy for three edges: EX frozen, stall held
        set_addi(32'h200, 5'd1, 5'd2, 32'd1);
        bus.ex_busy = 1'b1;
        #1;
        chk("busy_stall0", bus.stall, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("busy_pc4_%0d", i), bus.ex_pc4, 32'h120);
            chk($sformatf("busy_stall_%0d", i + 1), bus.stall, 1);
        end
        chk_cnt("busy_cnt", 4);
        bus.ex_busy = 1'b0;
        #1;
        chk("busy_released_stall", bus.stall, 0);
        step();
        chk("busy_after_pc4", bus.ex_pc4, 32'h200);

        // flush during load-use: flush wins, bubble, stall low
        set_lw(32'h204, 5'd2, 5'd9);
        step();
        set_add(32'h208, 5'd9, 5'd3, 5'd4);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", bus.stall, 0);
        step();
        chk("flush_valid", bus.ex_valid, 0);
        chk("flush_mem_read", bus.ex_mem_read, 0);
        chk("flush_reg_write", bus.ex_reg_write, 0);
        chk("flush_reg_dst", bus.ex_reg_dst, 0);
        chk("flush_alu_op", bus.ex_alu_op, 2'b00);
        bus.flush = 1'b0;

        // id_valid=0 loads zero control bits
        set_add(32'h20c, 5'd1, 5'd2, 5'd3);
        bus.id_valid = 1'b0;
        step();
        chk("invalid_valid", bus.ex_valid, 0);
        chk("invalid_reg_write", bus.ex_reg_write, 0);
        chk("invalid_reg_dst", bus.ex_reg_dst, 0);
        chk_cnt("invalid_cnt", 4);

        // reset pulse during ex_busy
        set_addi(32'h300, 5'd1, 5'd2, 32'd3);
        step();
        chk("pre_rst_pc4", bus.ex_pc4, 32'h300);
        bus.ex_busy = 1'b1;
        #1;
        chk("pre_rst_stall", bus.stall, 1);
        reset = 1'b0;
        #1;
        chk("midrst_stall", bus.stall, 0);
        chk("midrst_valid", bus.ex_valid, 0);
        chk("midrst_pc4", bus.ex_pc4, 0);
        chk("midrst_reg_write", bus.ex_reg_write, 0);
        chk_cnt("midrst_cnt", 0);
        bus.ex_busy = 1'b0;
        set_addi(32'h400, 5'd1, 5'd2, 32'd3);
        #1;
        reset = 1'b1;
        step();
        chk("postrst_valid", bus.ex_valid, 1);
        chk("postrst_pc4", bus.ex_pc4, 32'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath/operand width.
REQ-002 Parameter RADDR_W, default 5, register-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-005 id_valid  in  1  ID slot holds a real instruction.
REQ-006 id_reg_dst, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_write, id_branch, id_jump  in  1 each  decoded control.
REQ-007 id_alu_op  in  2  decoded ALU class.
REQ-008 id_pc4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, register reads, sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  in  RADDR_W each; id_funct  in  6.
REQ-010 flush  in  1  taken branch/jump redirect from later stage.
REQ-011 ex_busy  in  1  EX multi-cycle op (mult/div) not done.
REQ-012 stall  out  1  hold PC and IF/ID this cycle.
REQ-013 ex_valid, ex_* (one per REQ-006..009 input)  out  same widths  registered copies.
REQ-014 perf_stall_cnt  out  32  stall-cycle count (see Configuration).

Function
REQ-015 load_use SHALL be ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt & (~id_alu_src | id_mem_write | id_branch))).
REQ-016 Per-edge priority SHALL be: flush > ex_busy > load_use > normal load.
REQ-017 flush: ex_valid<=0, all ex_ control bits<=0 (bubble); data fields don't-care; stall=0.
REQ-018 ex_busy (no flush): all ex_ registers hold; stall=1.
REQ-019 load_use (no flush/busy): bubble inserted as REQ-017; stall=1.
REQ-020 Normal: all ex_ outputs <= id_ inputs, ex_valid<=id_valid; stall=0.
REQ-021 When id_valid=0 on normal load, control bits SHALL load as 0.
REQ-022 stall SHALL be combinational from current inputs and ex_ state; latency ID->EX one cycle.
REQ-023 Load-use stall SHALL last exactly one cycle (bubble clears ex_mem_read).
REQ-024 Back-to-back flush and load_use: flush wins; stall low.

Reset
REQ-025 While reset=0: ex_valid and all ex_ control bits 0, ex_ data/address fields 0, perf_stall_cnt 0.
REQ-026 Reset mid-stall SHALL drop stall on assertion; first post-reset edge performs normal load.

Configuration
REQ-027 Macro ID_EX_STALL_CNT_EN defined: perf_stall_cnt increments each edge where stall=1, saturates at 0xFFFFFFFF.
REQ-028 Macro undefined: counter not built, perf_stall_cnt tied 0; all other behaviour identical.

Structure
REQ-029 Shared package mips_pkg SHALL hold DATA_W/RADDR_W constants, ALU_OP encodings (00 add, 01 sub/branch, 10 R-type, 11 logical-imm), control-bundle typedef.
REQ-030 Sub-module hazard_detect SHALL compute load_use combinationally; pipeline register stays in id_ex_stage.

Verification
REQ-031 reset=0 then release, id_valid=1 addi rt=3 -> one edge later ex_valid=1, ex_reg_write=1, ex_alu_op=00, stall=0.
REQ-032 lw rt=5 followed by add rs=5 -> stall=1 one cycle, bubble (ex_valid=0), add enters EX next cycle, perf_stall_cnt=1 with macro.
REQ-033 lw rt=0 followed by add rs=0 -> no stall.
REQ-034 ex_busy=1 three cycles -> ex_ outputs frozen, stall=1 three cycles, counter +3.
REQ-035 flush=1 with load_use true -> stall=0, ex_valid=0, all ex_ control 0.
REQ-036 reset=0 pulse during ex_busy -> outputs zero immediately, stall=0.
